// File: rtl/sm83_alu_seq.sv
// SM83 ALU sequencer: drives a 4-bit ALU core through one 8-bit op
// (load A, load B, low nibble, high nibble, result) and returns data plus Z/N/H/C.
module sm83_alu_seq #(
  parameter int ALU_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [2:0]             i_req_op,
  input  logic [2*ALU_WIDTH-1:0] i_req_a,
  input  logic [2*ALU_WIDTH-1:0] i_req_b,
  input  logic                   i_req_cf,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [2*ALU_WIDTH-1:0] o_resp_data,
  output logic [3:0]             o_resp_flags,
  output logic [2*ALU_WIDTH-1:0] o_alu_din,
  input  logic [2*ALU_WIDTH-1:0] i_alu_dout,
  input  logic                   i_alu_carry,
  input  logic                   i_alu_zero,
  output logic                   o_alu_load_a,
  output logic                   o_alu_load_b,
  output logic                   o_alu_shift_oe,
  output logic                   o_alu_result_oe,
  output logic                   o_alu_op_low,
  output logic                   o_alu_op_b_high,
  output logic                   o_alu_negate,
  output logic                   o_alu_carry_in,
  output logic                   o_alu_no_carry_out,
  output logic                   o_alu_force_carry,
  output logic                   o_alu_ignore_carry
);

  localparam int DW = 2 * ALU_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_A, S_LD_B, S_LO, S_HI, S_RES, S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic            r_cf;
  logic            r_lc;
  logic            r_hc;

  logic            w_r;
  logic            w_s;
  logic            w_v;
  logic            w_neg;
  logic            w_cin;
  logic            w_arith;
  logic            w_sub;
  logic            w_h;
  logic            w_c;

  assign o_req_ready = (r_state == S_IDLE);

  // Core control word and flag rules for the latched op
  always_comb begin
    w_r     = 1'b0;
    w_s     = 1'b0;
    w_v     = 1'b0;
    w_neg   = 1'b0;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_sub   = 1'b0;
    unique case (r_op)
      3'd0: w_arith = 1'b1;
      3'd1: begin
        w_arith = 1'b1;
        w_cin   = r_cf;
      end
      3'd2, 3'd7: begin
        w_arith = 1'b1;
        w_sub   = 1'b1;
        w_neg   = 1'b1;
        w_cin   = 1'b1;
      end
      3'd3: begin
        w_arith = 1'b1;
        w_sub   = 1'b1;
        w_neg   = 1'b1;
        w_cin   = ~r_cf;
      end
      3'd4: begin
        w_s   = 1'b1;
        w_cin = 1'b1;
      end
      3'd5: w_r = 1'b1;
      3'd6: begin
        w_r = 1'b1;
        w_v = 1'b1;
      end
    endcase
    w_h = w_arith ? (w_sub ? ~r_lc : r_lc) : w_s;
    w_c = w_arith ? (w_sub ? ~r_hc : r_hc) : 1'b0;
  end

  // Sequencer FSM with registered core controls and response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_op               <= 3'd0;
      r_a                <= '0;
      r_b                <= '0;
      r_cf               <= 1'b0;
      r_lc               <= 1'b0;
      r_hc               <= 1'b0;
      o_resp_valid       <= 1'b0;
      o_resp_data        <= '0;
      o_resp_flags       <= 4'd0;
      o_alu_din          <= '0;
      o_alu_load_a       <= 1'b0;
      o_alu_load_b       <= 1'b0;
      o_alu_shift_oe     <= 1'b0;
      o_alu_result_oe    <= 1'b0;
      o_alu_op_low       <= 1'b0;
      o_alu_op_b_high    <= 1'b0;
      o_alu_negate       <= 1'b0;
      o_alu_carry_in     <= 1'b0;
      o_alu_no_carry_out <= 1'b0;
      o_alu_force_carry  <= 1'b0;
      o_alu_ignore_carry <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op           <= i_req_op;
            r_a            <= i_req_a;
            r_b            <= i_req_b;
            r_cf           <= i_req_cf;
            o_alu_din      <= i_req_a;
            o_alu_shift_oe <= 1'b1;
            o_alu_load_a   <= 1'b1;
            r_state        <= S_LD_A;
          end
        end
        S_LD_A: begin
          o_alu_din    <= r_b;
          o_alu_load_a <= 1'b0;
          o_alu_load_b <= 1'b1;
          r_state      <= S_LD_B;
        end
        S_LD_B: begin
          o_alu_din          <= '0;
          o_alu_shift_oe     <= 1'b0;
          o_alu_load_b       <= 1'b0;
          o_alu_op_low       <= 1'b1;
          o_alu_op_b_high    <= 1'b0;
          o_alu_negate       <= w_neg;
          o_alu_carry_in     <= w_cin;
          o_alu_no_carry_out <= w_r;
          o_alu_force_carry  <= w_s;
          o_alu_ignore_carry <= w_v;
          r_state            <= S_LO;
        end
        S_LO: begin
          // Low-nibble carry chains into the high nibble for arithmetic
          r_lc            <= i_alu_carry;
          o_alu_carry_in  <= w_arith ? i_alu_carry : w_cin;
          o_alu_op_low    <= 1'b0;
          o_alu_op_b_high <= 1'b1;
          r_state         <= S_HI;
        end
        S_HI: begin
          r_hc            <= i_alu_carry;
          o_alu_op_b_high <= 1'b0;
          o_alu_result_oe <= 1'b1;
          r_state         <= S_RES;
        end
        S_RES: begin
          o_resp_data        <= (r_op == 3'd7) ? r_a : i_alu_dout;
          o_resp_flags       <= {i_alu_zero, w_sub, w_h, w_c};
          o_resp_valid       <= 1'b1;
          o_alu_result_oe    <= 1'b0;
          o_alu_negate       <= 1'b0;
          o_alu_carry_in     <= 1'b0;
          o_alu_no_carry_out <= 1'b0;
          o_alu_force_carry  <= 1'b0;
          o_alu_ignore_carry <= 1'b0;
          r_state            <= S_DONE;
        end
        S_DONE: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Bench for sm83_alu_seq: behavioural 4-bit core, arithmetic reference
// model with per-cycle compare, and directed vectors with literal results.
module tb_sm83_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_cf;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic [3:0] resp_flags;
  logic [7:0] alu_din;
  logic [7:0] alu_dout;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_load_a;
  logic       alu_load_b;
  logic       alu_shift_oe;
  logic       alu_result_oe;
  logic       alu_op_low;
  logic       alu_op_b_high;
  logic       alu_negate;
  logic       alu_carry_in;
  logic       alu_r;
  logic       alu_s;
  logic       alu_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sm83_alu_seq #(.ALU_WIDTH(4)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_op           (req_op),
    .i_req_a            (req_a),
    .i_req_b            (req_b),
    .i_req_cf           (req_cf),
    .o_resp_valid       (resp_valid),
    .i_resp_ready       (resp_ready),
    .o_resp_data        (resp_data),
    .o_resp_flags       (resp_flags),
    .o_alu_din          (alu_din),
    .i_alu_dout         (alu_dout),
    .i_alu_carry        (alu_carry),
    .i_alu_zero         (alu_zero),
    .o_alu_load_a       (alu_load_a),
    .o_alu_load_b       (alu_load_b),
    .o_alu_shift_oe     (alu_shift_oe),
    .o_alu_result_oe    (alu_result_oe),
    .o_alu_op_low       (alu_op_low),
    .o_alu_op_b_high    (alu_op_b_high),
    .o_alu_negate       (alu_negate),
    .o_alu_carry_in     (alu_carry_in),
    .o_alu_no_carry_out (alu_r),
    .o_alu_force_carry  (alu_s),
    .o_alu_ignore_carry (alu_v)
  );

  // 4-bit core model
  logic [7:0] ca;
  logic [7:0] cb;
  logic [3:0] rlo;
  logic [3:0] rhi;
  logic [3:0] nx;
  logic [3:0] ny;
  logic [3:0] nf;
  logic       ncy;

  always_comb begin
    nx = alu_op_low ? ca[3:0] : ca[7:4];
    ny = alu_op_b_high ? cb[7:4] : cb[3:0];
    if (alu_negate) ny = ~ny;
    nf  = 4'd0;
    ncy = 1'b0;
    if (alu_s) begin
      nf  = nx & ny;
      ncy = 1'b1;
    end else if (alu_r && alu_v) begin
      nf = nx | ny;
    end else if (alu_r) begin
      nf = nx ^ ny;
    end else begin
      {ncy, nf} = {1'b0, nx} + {1'b0, ny} + {4'd0, alu_carry_in};
    end
    alu_dout = alu_result_oe ? {rhi, rlo} :
               (alu_shift_oe ? alu_din : 8'h00);
    alu_carry = ncy;
    alu_zero  = (alu_dout == 8'h00);
  end

  always @(posedge clk) begin
    if (alu_load_a) ca <= alu_din;
    if (alu_load_b) cb <= alu_din;
    if (alu_op_low) rlo <= nf;
    if (alu_op_b_high) rhi <= nf;
  end

  // Reference: {data, Z, N, H, C} from plain 8-bit arithmetic
  function automatic logic [11:0] ref_calc(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic cf);
    int ia, ib, c, r;
    logic [7:0] d;
    logic z, n, h, cy;
    ia = int'(a);
    ib = int'(b);
    c  = (op == 3'd1 || op == 3'd3) ? int'(cf) : 0;
    n = 1'b0; h = 1'b0; cy = 1'b0; d = 8'h00;
    case (op)
      3'd0, 3'd1: begin
        r  = ia + ib + c;
        d  = 8'(r);
        h  = ((ia % 16) + (ib % 16) + c) > 15;
        cy = r > 255;
      end
      3'd2, 3'd3, 3'd7: begin
        r  = ia - ib - c;
        d  = 8'(r);
        n  = 1'b1;
        h  = (ia % 16) < ((ib % 16) + c);
        cy = ia < (ib + c);
      end
      3'd4: begin
        d = a & b;
        h = 1'b1;
      end
      3'd5: d = a ^ b;
      default: d = a | b;
    endcase
    z = (d == 8'h00);
    if (op == 3'd7) d = a;
    return {d, z, n, h, cy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: 0 idle, 1..5 busy, 6 response pending
  int         m_st = 0;
  logic [7:0] m_data = 8'h00;
  logic [3:0] m_flags = 4'h0;

  always @(posedge clk) begin
    if (reset) begin
      m_st <= 0;
    end else if (m_st == 0) begin
      if (req_valid) begin
        m_st <= 1;
        {m_data, m_flags} <= ref_calc(req_op, req_a, req_b, req_cf);
      end
    end else if (m_st < 6) begin
      m_st <= m_st + 1;
    end else if (resp_ready) begin
      m_st <= 0;
    end
  end

  logic [18:0] ctl;
  assign ctl = {alu_din, alu_load_a, alu_load_b, alu_shift_oe,
                alu_result_oe, alu_op_low, alu_op_b_high, alu_negate,
                alu_carry_in, alu_r, alu_s, alu_v};

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready", 32'(req_ready), 32'(m_st == 0));
      chk("resp_valid", 32'(resp_valid), 32'(m_st == 6));
      if (m_st == 6) begin
        chk("model_data", 32'(resp_data), 32'(m_data));
        chk("model_flags", 32'(resp_flags), 32'(m_flags));
      end
      if (m_st == 0 || m_st == 6)
        chk("ctl_quiet", 32'(ctl), 32'd0);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cf,
                        input bit lit, input logic [7:0] ed,
                        input logic [3:0] ef, input int hold);
    int n;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_cf = cf;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = ~a; req_b = ~b; req_op = ~op;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resp_valid && n < 20);
    chk("latency", 32'(n), 32'd5);
    if (lit) begin
      chk("data", 32'(resp_data), 32'(ed));
      chk("flags", 32'(resp_flags), 32'(ef));
    end
    if (hold > 0) begin
      req_op = 3'd4; req_a = 8'hFF; req_b = 8'hFF;
      req_valid = 1'b1;
      repeat (hold) @(negedge clk);
      req_valid = 1'b0;
      if (lit) begin
        chk("stall_data", 32'(resp_data), 32'(ed));
        chk("stall_flags", 32'(resp_flags), 32'(ef));
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_a = 8'h00; req_b = 8'h00;
    req_cf = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_flags", 32'(resp_flags), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    reset = 1'b0;

    run_op(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b1, 8'h00, 4'b1011, 0);
    run_op(3'd3, 8'h3B, 8'h2A, 1'b1, 1'b1, 8'h10, 4'b0100, 0);
    run_op(3'd2, 8'h3E, 8'h3E, 1'b0, 1'b1, 8'h00, 4'b1100, 0);
    run_op(3'd4, 8'h5A, 8'h3F, 1'b0, 1'b1, 8'h1A, 4'b0010, 0);
    run_op(3'd5, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 4'b1000, 0);
    run_op(3'd6, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A, 4'b0000, 0);
    run_op(3'd7, 8'h3C, 8'h40, 1'b0, 1'b1, 8'h3C, 4'b0101, 0);
    run_op(3'd1, 8'h0F, 8'h00, 1'b1, 1'b1, 8'h10, 4'b0010, 0);
    run_op(3'd3, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 4'b0110, 0);
    run_op(3'd2, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 4'b0111, 0);
    run_op(3'd0, 8'h08, 8'h08, 1'b0, 1'b1, 8'h10, 4'b0010, 0);
    run_op(3'd7, 8'h42, 8'h42, 1'b1, 1'b1, 8'h42, 4'b1100, 0);

    // Consumer stalls 10 cycles while a new request is offered
    run_op(3'd6, 8'h81, 8'h18, 1'b0, 1'b1, 8'h99, 4'b0000, 10);

    // Reset while the core is in the high-nibble step
    @(negedge clk);
    req_op = 3'd0; req_a = 8'h77; req_b = 8'h11; req_cf = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("hi_rst_ready", 32'(req_ready), 32'd1);
    chk("hi_rst_valid", 32'(resp_valid), 32'd0);
    chk("hi_rst_ctl", 32'(ctl), 32'd0);
    run_op(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b1, 8'h00, 4'b1011, 0);

    // Model-checked sweep
    for (int i = 0; i < 24; i++) begin
      run_op(3'(i % 8), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             1'b0, 8'h00, 4'h0, (i % 5 == 0) ? 3 : 0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
